// File: rtl/tlb_front_if.sv
// Core request/response, page-table-walker and statistics signals of tlb_front.
// slave = TLB side, master = core/walker side; fully combinational bundle, no state.
// Backpressure is carried by the req/resp/walk/pwalk valid-ready pairs.
interface tlb_front_if;
    logic [63:0] req_vaddr;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] resp_paddr;
    logic        resp_fault;
    logic        resp_valid;
    logic        resp_ready;
    logic        flush;
    logic [63:0] walk_vaddr;
    logic        walk_valid;
    logic        walk_ready;
    logic [63:0] walk_paddr;
    logic        walk_fault;
    logic        walk_pvalid;
    logic        walk_pready;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    modport slave (
        input  req_vaddr, req_valid, resp_ready, flush,
               walk_ready, walk_paddr, walk_fault, walk_pvalid,
        output req_ready, resp_paddr, resp_fault, resp_valid,
               walk_vaddr, walk_valid, walk_pready, hit_count, miss_count
    );

    modport master (
        output req_vaddr, req_valid, resp_ready, flush,
               walk_ready, walk_paddr, walk_fault, walk_pvalid,
        input  req_ready, resp_paddr, resp_fault, resp_valid,
               walk_vaddr, walk_valid, walk_pready, hit_count, miss_count
    );
endinterface

// File: rtl/tlb_front.sv
// Fully associative Sv39 TLB in front of the page-table walker; TLB_STATS_EN adds hit/miss counters.
// Latency: hit answers 2 edges after the request handshake; a miss adds the walker round trip.
// Backpressure: one request in flight; req_ready low until the response handshakes.
module tlb_front #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input logic        clk,
    input logic        rst,
    tlb_front_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WALK_REQ  = 3'd2,
        WALK_WAIT = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [63:0]        vaddr_q;
    logic [26:0]        vpn_q;
    logic [63:0]        walk_vaddr_q;
    logic [63:0]        resp_paddr_q;
    logic               resp_fault_q;
    logic               flush_seen;

    logic [ENTRIES-1:0] ent_vld;
    logic [26:0]        ent_tag [ENTRIES];
    logic [51:0]        ent_ppn [ENTRIES];
    logic [IDX_W-1:0]   rpl_ptr;

    logic               hit;
    logic [51:0]        hit_ppn;
    logic               free_any;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   fill_idx;
    logic               pwalk_hs;
    logic               fill_en;

    assign vpn_q = vaddr_q[38:12];

    always_comb begin
        hit     = 1'b0;
        hit_ppn = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ent_vld[i] && (ent_tag[i] == vpn_q)) begin
                hit     = 1'b1;
                hit_ppn = ent_ppn[i];
            end
        end
    end

    // Descending scan so the lowest-index free slot wins.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!ent_vld[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign fill_idx = free_any ? free_idx : rpl_ptr;
    assign pwalk_hs = (state == WALK_WAIT) && bus.walk_pvalid;
    assign fill_en  = pwalk_hs && !bus.walk_fault && !bus.flush && !flush_seen;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (bus.req_valid)   state_nxt = LOOKUP;
            LOOKUP:    state_nxt = hit ? RESP : WALK_REQ;
            WALK_REQ:  if (bus.walk_ready)  state_nxt = WALK_WAIT;
            WALK_WAIT: if (bus.walk_pvalid) state_nxt = RESP;
            RESP:      if (bus.resp_ready)  state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vaddr_q      <= '0;
            walk_vaddr_q <= '0;
            resp_paddr_q <= '0;
            resp_fault_q <= 1'b0;
            flush_seen   <= 1'b0;
        end else begin
            if (state == IDLE && bus.req_valid) vaddr_q <= bus.req_vaddr;
            if (state == LOOKUP) begin
                flush_seen <= 1'b0;
                if (hit) begin
                    resp_paddr_q <= {hit_ppn, vaddr_q[11:0]};
                    resp_fault_q <= 1'b0;
                end else begin
                    walk_vaddr_q <= vaddr_q;
                end
            end
            // A flush anywhere in the walk means the returned translation may be stale.
            if ((state == WALK_REQ || state == WALK_WAIT) && bus.flush) flush_seen <= 1'b1;
            if (pwalk_hs) begin
                resp_paddr_q <= bus.walk_fault ? 64'd0 : bus.walk_paddr;
                resp_fault_q <= bus.walk_fault;
            end
            if (state == RESP && bus.resp_ready) resp_fault_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_vld <= '0;
            rpl_ptr <= '0;
        end else if (bus.flush) begin
            ent_vld <= '0;
        end else if (fill_en) begin
            ent_vld[fill_idx] <= 1'b1;
            if (!free_any) rpl_ptr <= rpl_ptr + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            ent_tag[fill_idx] <= vpn_q;
            ent_ppn[fill_idx] <= bus.walk_paddr[63:12];
        end
    end

    assign bus.req_ready   = (state == IDLE);
    assign bus.walk_valid  = (state == WALK_REQ);
    assign bus.walk_pready = (state == WALK_WAIT);
    assign bus.resp_valid  = (state == RESP);
    assign bus.walk_vaddr  = walk_vaddr_q;
    assign bus.resp_paddr  = resp_paddr_q;
    assign bus.resp_fault  = resp_fault_q;

`ifdef TLB_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == LOOKUP) begin
            if (hit) begin
                if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
            end else begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

    assign bus.hit_count  = hit_cnt;
    assign bus.miss_count = miss_cnt;
`else
    assign bus.hit_count  = '0;
    assign bus.miss_count = '0;
`endif
endmodule

// File: tb/tb_tlb_front.sv
// Self-checking bench for tlb_front: directed scenarios plus random traffic against a
// slot-list reference model of the TLB (lowest free slot, else round-robin pointer).
`timescale 1ns/1ps
module tb_tlb_front;
    localparam int ENTRIES = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    tlb_front_if bus();
    tlb_front #(.ENTRIES(ENTRIES)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_vld [ENTRIES];
    logic [26:0] m_vpn [ENTRIES];
    logic [51:0] m_ppn [ENTRIES];
    int          m_ptr;
    int          m_hits;
    int          m_misses;

    function automatic void m_reset();
        foreach (m_vld[i]) m_vld[i] = 1'b0;
        m_ptr = 0; m_hits = 0; m_misses = 0;
    endfunction

    function automatic void m_flush();
        foreach (m_vld[i]) m_vld[i] = 1'b0;
    endfunction

    function automatic bit m_find(input logic [63:0] va, output logic [51:0] ppn);
        ppn = '0;
        foreach (m_vld[i]) if (m_vld[i] && m_vpn[i] == va[38:12]) begin ppn = m_ppn[i]; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic void m_fill(input logic [63:0] va, input logic [63:0] pa);
        int slot = -1;
        foreach (m_vld[i]) if (slot < 0 && !m_vld[i]) slot = i;
        if (slot < 0) begin slot = m_ptr; m_ptr = (m_ptr + 1) % ENTRIES; end
        m_vld[slot] = 1'b1; m_vpn[slot] = va[38:12]; m_ppn[slot] = pa[63:12];
    endfunction

    function automatic int exp_hits();
`ifdef TLB_STATS_EN
        return m_hits;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_misses();
`ifdef TLB_STATS_EN
        return m_misses;
`else
        return 0;
`endif
    endfunction

    task automatic drive_idle();
        bus.req_vaddr = '0; bus.req_valid = 1'b0; bus.resp_ready = 1'b0; bus.flush = 1'b0;
        bus.walk_ready = 1'b0; bus.walk_paddr = '0; bus.walk_fault = 1'b0; bus.walk_pvalid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b0; drive_idle(); m_reset();
        @(negedge clk); rst = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_idle();
        #1 rst = 1'b0;
        #2;
        m_reset();
        checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_fault, bus.walk_valid, bus.walk_pready} !== 5'b10000) begin
            errors++; $display("FAIL reset/handshake got %b want 10000",
                {bus.req_ready, bus.resp_valid, bus.resp_fault, bus.walk_valid, bus.walk_pready});
        end
        checks++;
        if (bus.resp_paddr !== 64'd0) begin errors++; $display("FAIL reset/resp_paddr got %h want 0", bus.resp_paddr); end
        checks++;
        if (bus.walk_vaddr !== 64'd0) begin errors++; $display("FAIL reset/walk_vaddr got %h want 0", bus.walk_vaddr); end
        checks++;
        if (bus.hit_count !== 32'd0 || bus.miss_count !== 32'd0) begin
            errors++; $display("FAIL reset/counters got %0d/%0d want 0/0", bus.hit_count, bus.miss_count);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One full transaction, checked against the model; the model is updated afterwards.
    task automatic test_access(input string name, input logic [63:0] va, input logic [63:0] pa,
                               input logic flt, input bit flush_fill, input int hold);
        logic [51:0] eppn;
        bit          ehit;
        logic [63:0] epa;
        logic        eflt;
        bit          walked = 1'b0, got = 1'b0, tmo = 1'b1, stable = 1'b1;
        logic [63:0] wva = '0, rpa = '0;
        logic        rflt = 1'b0;
        int          lat = 0, edges, hold_left = hold;

        ehit = m_find(va, eppn);
        epa  = ehit ? {eppn, va[11:0]} : (flt ? 64'd0 : pa);
        eflt = !ehit && flt;

        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL %s/req_ready got %b want 1", name, bus.req_ready); end
        bus.req_vaddr = va; bus.req_valid = 1'b1;
        @(negedge clk); bus.req_valid = 1'b0; edges = 1;
        for (int i = 0; i < 200 && tmo; i++) begin
            bus.walk_ready = 1'b0; bus.walk_pvalid = 1'b0; bus.flush = 1'b0; bus.resp_ready = 1'b0;
            if (bus.walk_valid) begin
                walked = 1'b1; wva = bus.walk_vaddr;
                bus.walk_ready = ($urandom_range(0, 2) != 0);
            end
            if (bus.walk_pready && $urandom_range(0, 2) != 0) begin
                bus.walk_pvalid = 1'b1; bus.walk_paddr = pa; bus.walk_fault = flt; bus.flush = flush_fill;
            end
            if (bus.resp_valid) begin
                if (!got) begin
                    got = 1'b1; rpa = bus.resp_paddr; rflt = bus.resp_fault; lat = edges;
                end else if (bus.resp_paddr !== rpa || bus.resp_fault !== rflt || bus.req_ready !== 1'b0) begin
                    stable = 1'b0;
                end
                if (hold_left == 0) begin bus.resp_ready = 1'b1; tmo = 1'b0; end
                else hold_left--;
            end
            @(negedge clk); edges++;
        end
        drive_idle();

        checks++;
        if (tmo) begin errors++; $display("FAIL %s/timeout got no response want response", name); end
        checks++;
        if (walked !== !ehit) begin errors++; $display("FAIL %s/walked got %b want %b", name, walked, !ehit); end
        if (walked) begin
            checks++;
            if (wva !== va) begin errors++; $display("FAIL %s/walk_vaddr got %h want %h", name, wva, va); end
        end
        checks++;
        if (rpa !== epa) begin errors++; $display("FAIL %s/resp_paddr got %h want %h", name, rpa, epa); end
        checks++;
        if (rflt !== eflt) begin errors++; $display("FAIL %s/resp_fault got %b want %b", name, rflt, eflt); end
        if (ehit) begin
            checks++;
            if (lat != 2) begin errors++; $display("FAIL %s/hit_latency got %0d want 2", name, lat); end
        end
        if (hold > 0) begin
            checks++;
            if (!stable) begin errors++; $display("FAIL %s/resp_stable got unstable want stable", name); end
        end

        if (ehit) m_hits++;
        else begin
            m_misses++;
            if (flush_fill) m_flush();
            else if (!flt) m_fill(va, pa);
        end
    endtask

    task automatic test_counters(input string name);
        @(negedge clk);
        checks++;
        if (bus.hit_count !== 32'(exp_hits()) || bus.miss_count !== 32'(exp_misses())) begin
            errors++; $display("FAIL %s/counters got %0d/%0d want %0d/%0d", name,
                bus.hit_count, bus.miss_count, exp_hits(), exp_misses());
        end
    endtask

    task automatic test_cold_hit_fault();
        test_access("cold_miss", 64'h1234_5678, 64'h8765_4678, 1'b0, 1'b0, 0);
        test_access("hit", 64'h1234_5ABC, {$urandom, $urandom}, 1'b0, 1'b0, 0);
        test_counters("after_hit");
        test_access("fault", 64'h0000_9000, {$urandom, $urandom}, 1'b1, 1'b0, 0);
        test_access("fault_repeat", 64'h0000_9000, 64'hABCD_E000, 1'b0, 1'b0, 0);
    endtask

    task automatic test_replacement();
        do_reset();
        for (int v = 1; v <= 8; v++)
            test_access("fill", {37'd0, 15'(v), 12'h000}, {20'd0, 32'($urandom), 12'h000}, 1'b0, 1'b0, 0);
        test_access("evict_vpn9", 64'h0000_9000, 64'h0009_9000, 1'b0, 1'b0, 0);
        test_access("vpn2_hits", 64'h0000_2010, 64'h0, 1'b0, 1'b0, 0);
        test_access("vpn1_misses", 64'h0000_1020, 64'h0001_1000, 1'b0, 1'b0, 0);
        test_counters("after_replacement");
    endtask

    task automatic test_flush_race();
        test_access("flush_race", 64'h0005_5000, 64'h0055_5000, 1'b0, 1'b1, 0);
        test_access("vpn55_again", 64'h0005_5004, 64'h0055_5000, 1'b0, 1'b0, 0);
        test_access("vpn9_flushed", 64'h0000_9008, 64'h0009_9000, 1'b0, 1'b0, 0);
        test_access("vpn2_flushed", 64'h0000_200C, 64'h0002_2000, 1'b0, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        test_access("backpressure_hit", 64'h0000_2ABC, 64'h0, 1'b0, 1'b0, 5);
        test_access("backpressure_miss", 64'h0000_7000, 64'h0077_7000, 1'b0, 1'b0, 5);
    endtask

    task automatic test_reset_mid_walk();
        @(negedge clk);
        bus.req_vaddr = 64'h0007_7700; bus.req_valid = 1'b1;
        @(negedge clk); bus.req_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.walk_pready; i++) begin
            bus.walk_ready = bus.walk_valid;
            @(negedge clk);
        end
        bus.walk_ready = 1'b0;
        checks++;
        if (bus.walk_pready !== 1'b1) begin errors++; $display("FAIL reset_walk/reach_wait got %b want 1", bus.walk_pready); end
        #2 rst = 1'b0;
        #1;
        m_reset();
        checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_fault, bus.walk_valid, bus.walk_pready} !== 5'b10000) begin
            errors++; $display("FAIL reset_walk/handshake got %b want 10000",
                {bus.req_ready, bus.resp_valid, bus.resp_fault, bus.walk_valid, bus.walk_pready});
        end
        checks++;
        if (bus.walk_vaddr !== 64'd0 || bus.resp_paddr !== 64'd0) begin
            errors++; $display("FAIL reset_walk/addrs got %h/%h want 0/0", bus.walk_vaddr, bus.resp_paddr);
        end
        checks++;
        if (bus.hit_count !== 32'd0 || bus.miss_count !== 32'd0) begin
            errors++; $display("FAIL reset_walk/counters got %0d/%0d want 0/0", bus.hit_count, bus.miss_count);
        end
        @(negedge clk); rst = 1'b1;
        test_access("after_reset_miss", 64'h0000_2ABC, 64'h0022_2000, 1'b0, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [63:0] va, pa;
            va = {25'($urandom), 27'($urandom_range(1, 12)), 12'($urandom)};
            pa = {$urandom, $urandom};
            test_access("random", va, pa, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                        $urandom_range(0, 2));
        end
        test_counters("after_random");
    endtask

    initial begin
        test_reset();
        test_cold_hit_fault();
        test_replacement();
        test_flush_race();
        test_backpressure();
        test_reset_mid_walk();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tlb_front.md
Name: tlb_front

Overview:
- Fully associative translation lookaside buffer placed directly upstream of the page-table walker (MMU).
- Accepts virtual-address requests from the core and answers hits locally.
- On a miss, forwards the request to the walker over a valid/ready channel, caches the returned translation, and replies to the core.
- One request outstanding at a time; Sv39 virtual page number (vaddr[38:12]), 4 KiB pages.

Parameters:
ENTRIES, 8, number of TLB entries (power of two, 2..32)
IDX_W, $clog2(ENTRIES), width of entry index and replacement pointer

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous active-low reset
req_vaddr  in  64  core virtual address
req_valid  in  1  core request valid
req_ready  out  1  TLB can accept a request
resp_paddr  out  64  translated physical address
resp_fault  out  1  walker reported a fault; resp_paddr is 0
resp_valid  out  1  response valid
resp_ready  in  1  core accepts response
flush  in  1  invalidate all entries
walk_vaddr  out  64  miss address to walker
walk_valid  out  1  miss request valid
walk_ready  in  1  walker accepts miss
walk_paddr  in  64  walker result (full physical address)
walk_fault  in  1  walker fault, qualified by walk_pvalid
walk_pvalid  in  1  walker result valid
walk_pready  out  1  TLB accepts walker result
hit_count  out  32  hit counter (see Optional Feature)
miss_count  out  32  miss counter (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all entry valid bits 0; replacement pointer 0; req_ready=1; resp_valid=0, resp_fault=0, resp_paddr=0; walk_valid=0, walk_vaddr=0; walk_pready=0; counters 0. Reset asserted mid-walk abandons the walk; the walker is not notified.
- Entry contents: valid bit, 27-bit VPN tag (vaddr[38:12]), 52-bit PPN (walk_paddr[63:12]).
- IDLE: req_ready=1. On req_valid&&req_ready, register req_vaddr, drop req_ready, go to LOOKUP.
- LOOKUP (one cycle):
  - Compare the VPN against all valid entries.
  - Hit: resp_paddr={PPN, vaddr[11:0]}, resp_fault=0, resp_valid=1, go to RESP. resp_valid rises 2 edges after the request handshake edge.
  - Miss: walk_vaddr=registered vaddr, walk_valid=1, go to WALK_REQ.
- WALK_REQ: hold walk_valid and walk_vaddr stable until walk_ready. On handshake: walk_valid=0, walk_pready=1, go to WALK_WAIT.
- WALK_WAIT: on walk_pvalid&&walk_pready: walk_pready=0; go to RESP with resp_valid=1.
  - If walk_fault=1: resp_fault=1, resp_paddr=0, no fill.
  - Else: resp_paddr=walk_paddr, resp_fault=0, and fill one entry. Fill target is the lowest-index invalid entry; if none is invalid, the entry at the replacement pointer, which then increments modulo ENTRIES. The pointer does not move when an invalid slot is used.
- RESP: hold resp_* stable until resp_ready. On handshake: resp_valid=0, resp_fault=0, req_ready=1, go to IDLE. A new request is accepted no earlier than the cycle after return to IDLE.
- flush=1 at an edge clears all valid bits; the replacement pointer is unchanged.
  - Flush in LOOKUP: the lookup uses pre-flush contents.
  - Flush coinciding with a fill edge, or any flush while in WALK_REQ or WALK_WAIT: suppress that fill. The response is still delivered.
- Illegal state encoding returns to IDLE.

Optional Feature:
TLB_STATS_EN
- Defined: hit_count increments on each LOOKUP hit, and miss_count on each LOOKUP miss. Both saturate at 0xFFFF_FFFF and are cleared only by reset.
- Undefined: hit_count and miss_count are constant 0 and no counter flops exist. All other behaviour is identical.

Test Plan:
- Cold miss: reset, req_vaddr=0x1234_5678; walker returns walk_paddr=0x8765_4678, walk_fault=0 -> walk_vaddr=0x1234_5678 observed; resp_paddr=0x8765_4678, resp_fault=0; one entry filled.
- Hit: after the cold miss, req_vaddr=0x1234_5ABC -> no walk_valid; resp_paddr=0x8765_4ABC; resp_valid 2 edges after the request handshake; with TLB_STATS_EN, hit_count=1, miss_count=1.
- Fault: req_vaddr=0x0000_9000, walker returns walk_fault=1 -> resp_fault=1, resp_paddr=0. A repeat request walks again (no fill).
- Replacement: fill 8 distinct VPNs 0x1..0x8, then VPN 0x9 -> 0x9 overwrites entry 0 (pointer 0->1). A request for VPN 0x1 then misses; VPN 0x2 hits.
- Flush race: assert flush on the same edge as walk_pvalid for VPN 0x55 -> response delivered; subsequent VPN 0x55 request misses; all prior entries miss.
- Backpressure/reset: hold resp_ready=0 for 5 cycles -> resp_paddr stable, req_ready=0. Drop rst while in WALK_WAIT -> all outputs return to reset values immediately; next request misses.
